// File: rtl/psf_io_bridge.sv
// psf_io_bridge: AXI4 single-beat slave for the main I/O region, bridged onto a held-request peripheral register bus.
module psf_io_bridge #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        axi_awvalid_i,
  input  logic [31:0] axi_awaddr_i,
  input  logic [3:0]  axi_awid_i,
  input  logic [7:0]  axi_awlen_i,
  output logic        axi_awready_o,
  input  logic        axi_wvalid_i,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wlast_i,
  output logic        axi_wready_o,
  output logic        axi_bvalid_o,
  output logic [1:0]  axi_bresp_o,
  output logic [3:0]  axi_bid_o,
  input  logic        axi_bready_i,
  input  logic        axi_arvalid_i,
  input  logic [31:0] axi_araddr_i,
  input  logic [3:0]  axi_arid_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [2:0]  axi_arsize_i,
  output logic        axi_arready_o,
  output logic        axi_rvalid_o,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [3:0]  axi_rid_o,
  output logic        axi_rlast_o,
  input  logic        axi_rready_i,
  output logic [31:0] io_addr_o,
  output logic        io_rd_o,
  output logic [3:0]  io_wr_o,
  output logic [1:0]  io_size_o,
  output logic [31:0] io_data_wr_o,
  input  logic [31:0] io_data_rd_i,
  input  logic        io_ack_i,
  input  logic        io_error_i
);
  typedef enum logic [2:0] {IDLE, WCOLLECT, DRAIN, IO_RD, IO_WR, RESP_R, RESP_B} state_t;
  state_t                state_q, state_d;
  logic                  live_q;
  logic                  prio_q, prio_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                  len_nz_q, len_nz_d, wlast_q, wlast_d;
  logic [31:0]           addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]            id_q, id_d, wstrb_q, wstrb_d;
  logic [1:0]            size_q, size_d, resp_q, resp_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic                  idle, coll, ar_hs, aw_hs, w_hs, aw_h, w_h, lnz, last;
  logic [3:0]            strb;
  // live_q keeps every ready low until the first clock after reset
  assign idle          = live_q && state_q == IDLE;
  assign coll          = state_q == WCOLLECT;
  assign axi_arready_o = idle && (!axi_awvalid_i || !prio_q);
  assign ar_hs         = axi_arready_o && axi_arvalid_i;
  assign axi_awready_o = (idle && !ar_hs) || (coll && !aw_held_q);
  assign axi_wready_o  = (idle && !ar_hs) || (coll && !w_held_q) || state_q == DRAIN;
  assign aw_hs         = axi_awvalid_i && axi_awready_o;
  assign w_hs          = axi_wvalid_i && axi_wready_o;
  assign aw_h          = aw_held_q || aw_hs;
  assign w_h           = w_held_q || w_hs;
  assign lnz           = aw_held_q ? len_nz_q : axi_awlen_i != 8'd0;
  assign strb          = w_held_q ? wstrb_q : axi_wstrb_i;
  assign last          = w_held_q ? wlast_q : axi_wlast_i;
  assign cnt_inc       = cnt_q + 1'b1;
  assign axi_bvalid_o  = state_q == RESP_B;
  assign axi_bresp_o   = resp_q;
  assign axi_bid_o     = id_q;
  assign axi_rvalid_o  = state_q == RESP_R;
  assign axi_rdata_o   = rdata_q;
  assign axi_rresp_o   = resp_q;
  assign axi_rid_o     = id_q;
  assign axi_rlast_o   = state_q == RESP_R;
  assign io_addr_o     = addr_q;
  assign io_rd_o       = state_q == IO_RD;
  assign io_wr_o       = state_q == IO_WR ? wstrb_q : 4'd0;
  assign io_size_o     = size_q;
  assign io_data_wr_o  = wdata_q;
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    len_nz_d  = len_nz_q;
    wlast_d   = wlast_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    id_d      = id_q;
    wstrb_d   = wstrb_q;
    size_d    = size_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, WCOLLECT: begin
        if (ar_hs) begin
          addr_d  = axi_araddr_i;
          id_d    = axi_arid_i;
          size_d  = axi_arsize_i[2] ? 2'd2 : axi_arsize_i[1:0];
          prio_d  = !prio_q;
          cnt_d   = '0;
          resp_d  = axi_arlen_i != 8'd0 ? 2'b10 : 2'b00;
          rdata_d = axi_arlen_i != 8'd0 ? 32'd0 : rdata_q;
          state_d = axi_arlen_i != 8'd0 ? RESP_R : IO_RD;
        end else begin
          if (aw_hs) begin
            addr_d    = axi_awaddr_i;
            id_d      = axi_awid_i;
            len_nz_d  = axi_awlen_i != 8'd0;
            size_d    = 2'd2;
            aw_held_d = 1'b1;
            prio_d    = !prio_q;
          end
          if (w_hs) begin
            wdata_d  = axi_wdata_i;
            wstrb_d  = axi_wstrb_i;
            wlast_d  = axi_wlast_i;
            w_held_d = 1'b1;
          end
          if (aw_h && w_h) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            cnt_d     = '0;
            resp_d    = lnz ? 2'b10 : 2'b00;
            state_d   = lnz ? (last ? RESP_B : DRAIN) : (strb == 4'd0 ? RESP_B : IO_WR);
          end else if (aw_h || w_h) begin
            state_d = WCOLLECT;
          end
        end
      end
      DRAIN: state_d = axi_wvalid_i && axi_wlast_i ? RESP_B : DRAIN;
      IO_RD, IO_WR: begin
        cnt_d = cnt_inc;
        // a same-cycle ack beats the timeout
        if (io_ack_i) begin
          rdata_d = state_q == IO_RD ? io_data_rd_i : rdata_q;
          resp_d  = io_error_i ? 2'b10 : 2'b00;
          state_d = state_q == IO_RD ? RESP_R : RESP_B;
        end else if (&cnt_inc) begin
          rdata_d = state_q == IO_RD ? 32'd0 : rdata_q;
          resp_d  = 2'b10;
          state_d = state_q == IO_RD ? RESP_R : RESP_B;
        end
      end
      RESP_R: state_d = axi_rready_i ? IDLE : RESP_R;
      RESP_B: state_d = axi_bready_i ? IDLE : RESP_B;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      live_q    <= 1'b0;
      prio_q    <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      len_nz_q  <= 1'b0;
      wlast_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      id_q      <= '0;
      wstrb_q   <= '0;
      size_q    <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      prio_q    <= prio_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      len_nz_q  <= len_nz_d;
      wlast_q   <= wlast_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      id_q      <= id_d;
      wstrb_q   <= wstrb_d;
      size_q    <= size_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_psf_io_bridge.sv
// tb_psf_io_bridge: directed-vector bench for psf_io_bridge with hand-computed expectations.
module tb_psf_io_bridge;
  logic        clk = 0, rst_i = 1;
  logic        axi_awvalid_i = 0, axi_wvalid_i = 0, axi_wlast_i = 0, axi_bready_i = 0;
  logic        axi_arvalid_i = 0, axi_rready_i = 0, io_ack_i = 0, io_error_i = 0;
  logic [31:0] axi_awaddr_i = 0, axi_wdata_i = 0, axi_araddr_i = 0, io_data_rd_i = 0;
  logic [3:0]  axi_awid_i = 0, axi_wstrb_i = 0, axi_arid_i = 0;
  logic [7:0]  axi_awlen_i = 0, axi_arlen_i = 0;
  logic [2:0]  axi_arsize_i = 0;
  logic        axi_awready_o, axi_wready_o, axi_bvalid_o, axi_arready_o, axi_rvalid_o, axi_rlast_o, io_rd_o;
  logic [1:0]  axi_bresp_o, axi_rresp_o, io_size_o;
  logic [3:0]  axi_bid_o, axi_rid_o, io_wr_o;
  logic [31:0] axi_rdata_o, io_addr_o, io_data_wr_o;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_wr;
  logic [1:0]  req_size;
  int          n_cmp = 0, n_bad = 0, lat, hi;
  always #5 clk = ~clk;
  psf_io_bridge #(.TIMEOUT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .axi_awvalid_i(axi_awvalid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i),
    .axi_awlen_i(axi_awlen_i), .axi_awready_o(axi_awready_o),
    .axi_wvalid_i(axi_wvalid_i), .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i),
    .axi_wlast_i(axi_wlast_i), .axi_wready_o(axi_wready_o),
    .axi_bvalid_o(axi_bvalid_o), .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o), .axi_bready_i(axi_bready_i),
    .axi_arvalid_i(axi_arvalid_i), .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
    .axi_arlen_i(axi_arlen_i), .axi_arsize_i(axi_arsize_i), .axi_arready_o(axi_arready_o),
    .axi_rvalid_o(axi_rvalid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .axi_rid_o(axi_rid_o), .axi_rlast_o(axi_rlast_o), .axi_rready_i(axi_rready_i),
    .io_addr_o(io_addr_o), .io_rd_o(io_rd_o), .io_wr_o(io_wr_o), .io_size_o(io_size_o),
    .io_data_wr_o(io_data_wr_o), .io_data_rd_i(io_data_rd_i), .io_ack_i(io_ack_i), .io_error_i(io_error_i)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // cycle 1 starts on entry; acks in cycle ack_cyc (0 = never), stops when a response is valid
  task automatic wait_resp(input int ack_cyc, input logic [31:0] d, input logic err, output int l, output int h);
    l = 0;
    h = 0;
    for (int c = 1; c < 400; c++) begin
      io_ack_i = c == ack_cyc;
      io_data_rd_i = c == ack_cyc ? d : 32'hDEAD_BEEF;
      io_error_i = c == ack_cyc && err;
      #1;
      if (c == 1) begin
        req_addr = io_addr_o;
        req_size = io_size_o;
        req_wr = io_wr_o;
        req_data = io_data_wr_o;
      end
      if (axi_rvalid_o || axi_bvalid_o) begin
        l = c;
        break;
      end
      if (io_rd_o || io_wr_o != 4'd0) h++;
      @(posedge clk); #1;
    end
    io_ack_i = 0;
    io_error_i = 0;
    if (l == 0) chk("resp_bound", 0, 1);
  endtask
  task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz, input int ack,
                    input logic [31:0] d, input logic err, input logic [1:0] er, input logic [31:0] ed,
                    input int elat, input int ehi, input int hold);
    axi_arvalid_i = 1;
    axi_araddr_i = a;
    axi_arid_i = 8;
    axi_arlen_i = len;
    axi_arsize_i = sz;
    #1;
    chk("arready", axi_arready_o, 1);
    @(posedge clk); #1;
    axi_arvalid_i = 0;
    wait_resp(ack, d, err, lat, hi);
    chk("rd_lat", lat, elat);
    chk("rd_req_cycles", hi, ehi);
    if (ehi > 0) begin
      chk("rd_addr", req_addr, a);
      chk("rd_size", req_size, sz[1:0]);
    end
    chk("rvalid", axi_rvalid_o, 1);
    chk("rdata", axi_rdata_o, ed);
    chk("rresp", axi_rresp_o, er);
    chk("rid", axi_rid_o, 8);
    chk("rlast", axi_rlast_o, 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_rvalid", axi_rvalid_o, 1);
      chk("hold_rdata", axi_rdata_o, ed);
      chk("hold_arready", axi_arready_o, 0);
    end
    axi_rready_i = 1;
    @(posedge clk); #1;
    axi_rready_i = 0;
    #1;
    chk("r_done", axi_rvalid_o, 0);
  endtask
  // mode 0: AW and W together, 1: W two cycles before AW, 2: AW two cycles before W
  task automatic wr(input int mode, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int ack, input logic [1:0] er, input int elat, input int ehi);
    axi_awaddr_i = a;
    axi_awid_i = 8;
    axi_awlen_i = 0;
    axi_wdata_i = d;
    axi_wstrb_i = s;
    axi_wlast_i = 1;
    if (mode == 1) begin
      axi_wvalid_i = 1;
      #1 chk("w_first_rdy", axi_wready_o, 1);
      @(posedge clk); #1;
      axi_wvalid_i = 0;
      #1;
      chk("wc_arready", axi_arready_o, 0);
      chk("wc_awready", axi_awready_o, 1);
      @(posedge clk); #1;
    end
    if (mode == 2) begin
      axi_awvalid_i = 1;
      #1 chk("aw_first_rdy", axi_awready_o, 1);
      @(posedge clk); #1;
      axi_awvalid_i = 0;
      #1;
      chk("wc_arready", axi_arready_o, 0);
      chk("wc_wready", axi_wready_o, 1);
      @(posedge clk); #1;
    end
    axi_awvalid_i = mode != 2;
    axi_wvalid_i = mode != 1;
    #1;
    chk("aw_w_rdy", {axi_awready_o, axi_wready_o}, {mode != 2, mode != 1});
    @(posedge clk); #1;
    axi_awvalid_i = 0;
    axi_wvalid_i = 0;
    wait_resp(ack, 0, 0, lat, hi);
    chk("wr_lat", lat, elat);
    chk("wr_req_cycles", hi, ehi);
    if (ehi > 0) begin
      chk("wr_strb", req_wr, s);
      chk("wr_addr", req_addr, a);
      chk("wr_data", req_data, d);
      chk("wr_size", req_size, 2);
    end
    chk("bvalid", axi_bvalid_o, 1);
    chk("bresp", axi_bresp_o, er);
    chk("bid", axi_bid_o, 8);
    axi_bready_i = 1;
    @(posedge clk); #1;
    axi_bready_i = 0;
    #1;
    chk("b_done", axi_bvalid_o, 0);
  endtask
  initial begin
    #2;
    chk("rst_ready", {axi_awready_o, axi_wready_o, axi_arready_o}, 0);
    chk("rst_valid", {axi_rvalid_o, axi_bvalid_o}, 0);
    chk("rst_io", {io_rd_o, io_wr_o}, 0);
    chk("rst_addr", io_addr_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    @(posedge clk); #1;
    rd(32'h1F80_1070, 0, 2, 3, 32'hA5A5_1234, 0, 2'b00, 32'hA5A5_1234, 4, 3, 0);
    rd(32'h1F80_1074, 0, 0, 1, 32'h0000_00AB, 1, 2'b10, 32'h0000_00AB, 2, 1, 0);
    wr(1, 32'h1F80_1040, 32'h0000_00FF, 4'b0001, 2, 2'b00, 3, 2);
    wr(2, 32'h1F80_1040, 32'h0000_00FF, 4'b0001, 1, 2'b00, 2, 1);
    wr(0, 32'h1F80_1040, 32'h0000_00FF, 4'b0001, 3, 2'b00, 4, 3);
    wr(0, 32'h1F80_1044, 32'h1234_5678, 4'b0000, 0, 2'b00, 1, 0);
    rd(32'h1F80_1100, 0, 2, 0, 32'h0, 0, 2'b10, 32'h0, 256, 255, 0);
    rd(32'h1F80_1104, 0, 2, 255, 32'h1234_5678, 0, 2'b00, 32'h1234_5678, 256, 255, 0);
    // awlen = 1: two beats sunk, no peripheral access, error response
    axi_awvalid_i = 1; axi_awaddr_i = 32'h1F80_1048; axi_awid_i = 8; axi_awlen_i = 1;
    axi_wvalid_i = 1; axi_wdata_i = 32'h1111_1111; axi_wstrb_i = 4'hF; axi_wlast_i = 0;
    @(posedge clk); #1;
    axi_awvalid_i = 0; axi_awlen_i = 0; axi_wdata_i = 32'h2222_2222; axi_wlast_i = 1;
    #1;
    chk("drain_io_wr", io_wr_o, 0);
    chk("drain_wready", axi_wready_o, 1);
    chk("drain_bvalid", axi_bvalid_o, 0);
    @(posedge clk); #1;
    axi_wvalid_i = 0;
    #1;
    chk("drain_bvalid2", axi_bvalid_o, 1);
    chk("drain_bresp", axi_bresp_o, 2'b10);
    chk("drain_io_wr2", io_wr_o, 0);
    axi_bready_i = 1;
    @(posedge clk); #1;
    axi_bready_i = 0;
    rd(32'h1F80_1078, 3, 2, 0, 32'h0, 0, 2'b10, 32'h0, 1, 0, 0);
    rd(32'h1F80_1080, 0, 1, 1, 32'hCAFE_F00D, 0, 2'b00, 32'hCAFE_F00D, 2, 1, 5);
    // reset while a write request is outstanding, then a stray ack
    axi_awvalid_i = 1; axi_awaddr_i = 32'h1F80_1050; axi_wvalid_i = 1; axi_wstrb_i = 4'b0011; axi_wlast_i = 1;
    @(posedge clk); #1;
    axi_awvalid_i = 0; axi_wvalid_i = 0;
    #1 chk("pre_rst_io_wr", io_wr_o, 4'b0011);
    rst_i = 1;
    #1;
    chk("mid_rst_io", {io_rd_o, io_wr_o}, 0);
    chk("mid_rst_ready", {axi_awready_o, axi_wready_o, axi_arready_o}, 0);
    chk("mid_rst_valid", {axi_rvalid_o, axi_bvalid_o}, 0);
    chk("mid_rst_addr", io_addr_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    io_ack_i = 1;
    @(posedge clk); #1;
    io_ack_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stray_ack_resp", {axi_rvalid_o, axi_bvalid_o, io_rd_o, io_wr_o}, 0);
      @(posedge clk); #1;
    end
    chk("post_rst_awready", axi_awready_o, 1);
    // sustained AR/AW contention alternates R, W, R, W starting read-first
    for (int k = 0; k < 4; k++) begin
      axi_arvalid_i = 1; axi_araddr_i = 32'h1F80_1090; axi_arid_i = 8; axi_arlen_i = 0; axi_arsize_i = 2;
      axi_awvalid_i = 1; axi_awaddr_i = 32'h1F80_1094; axi_awid_i = 8; axi_awlen_i = 0;
      axi_wvalid_i = 1; axi_wdata_i = k; axi_wstrb_i = 4'hF; axi_wlast_i = 1;
      #1;
      chk("grant_ar", axi_arready_o, k % 2 == 0);
      chk("grant_aw", axi_awready_o, k % 2 == 1);
      @(posedge clk); #1;
      if (k % 2 == 0) axi_arvalid_i = 0;
      else begin
        axi_awvalid_i = 0;
        axi_wvalid_i = 0;
      end
      wait_resp(1, 32'h5000_0000 + k, 0, lat, hi);
      chk("alt_kind", axi_rvalid_o, k % 2 == 0);
      chk("alt_lat", lat, 2);
      chk("alt_busy_arready", axi_arready_o, 0);
      axi_rready_i = 1; axi_bready_i = 1;
      @(posedge clk); #1;
      axi_rready_i = 0; axi_bready_i = 0;
    end
    axi_arvalid_i = 0; axi_awvalid_i = 0; axi_wvalid_i = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
